// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port and the shared memory port.
// slave  : the arbiter's view (takes requests, drives acks and the memory request).
// master : the environment's view (requesters plus memory).
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        m_req;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_rw, m_addr, m_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_rw, m_addr, m_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory port with an ack timeout.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin contended arbitration;
// otherwise the data port always wins a contended cycle.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } state_e;

    // Wait-count value in the last cycle before the counter reaches TIMEOUT_CYCLES.
    localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        ready_q;
    logic [15:0] wait_q;
    logic        idle, i_elig, d_elig, grant_i, grant_d;
    logic        busy, finish, abort;
    logic        m_rw_q;
    logic [31:0] m_addr_q, m_wdata_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        i_ack_q, d_ack_q, err_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_d_q;  // 1: data port was granted most recently
`endif

    // Eligibility and grant selection; a port whose ack is showing sits this cycle out.
    always_comb begin
        idle   = (state_q == StIdle);
        i_elig = ready_q && idle && bus.i_req && !i_ack_q;
        d_elig = ready_q && idle && bus.d_req && !d_ack_q;
`ifdef ARB_ROUND_ROBIN_EN
        grant_i = i_elig && (!d_elig || last_d_q);
`else
        grant_i = i_elig && !d_elig;
`endif
        grant_d = d_elig && !grant_i;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_i) begin
                    state_d = StGntI;
                end else if (grant_d) begin
                    state_d = StGntD;
                end
            end
            StGntI, StGntD: begin
                if (finish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode: memory request follows the grant states; completion beats timeout.
    always_comb begin
        busy      = (state_q != StIdle);
        finish    = busy && (bus.m_ack || (wait_q == WaitLast));
        abort     = busy && !bus.m_ack && (wait_q == WaitLast);
        bus.m_req = busy;
    end

    // Registered datapath: grant capture, wait counter, ack/err pulses, read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q   <= 1'b0;
            wait_q    <= '0;
            m_rw_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b1;
`endif
        end else begin
            // Holds off the first grant until the second edge after reset release.
            ready_q <= 1'b1;
            i_ack_q <= finish && (state_q == StGntI);
            d_ack_q <= finish && (state_q == StGntD);
            err_q   <= abort;

            if (busy && !finish) begin
                wait_q <= wait_q + 16'd1;
            end else begin
                wait_q <= '0;
            end

            if (grant_i) begin
                m_rw_q    <= 1'b0;
                m_addr_q  <= bus.i_addr;
                m_wdata_q <= '0;
            end else if (grant_d) begin
                m_rw_q    <= bus.d_rw;
                m_addr_q  <= bus.d_addr;
                m_wdata_q <= bus.d_rw ? bus.d_wdata : '0;
            end

            if (finish && (state_q == StGntI)) begin
                i_rdata_q <= abort ? '0 : bus.m_rdata;
            end
            if (finish && (state_q == StGntD)) begin
                if (abort) begin
                    d_rdata_q <= '0;
                end else if (!m_rw_q) begin
                    d_rdata_q <= bus.m_rdata;
                end
            end

`ifdef ARB_ROUND_ROBIN_EN
            if (grant_i) begin
                last_d_q <= 1'b0;
            end else if (grant_d) begin
                last_d_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.m_rw    = m_rw_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT_CYCLES = 4): directed scenarios with
// literal expectations plus a transaction-level model compared every cycle.
module tb_mem_arbiter;
    localparam int TO = 4;

    logic clk;
    logic reset;
    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: acks after mem_wait cycles of m_req (mem_wait >= 255 means never).
    int mem_wait = 0;
    int mcnt     = 0;
    always @(negedge clk) begin
        if (reset || !bus.m_req) begin
            bus.m_ack = 1'b0;
            mcnt      = 0;
        end else begin
            bus.m_ack = (mcnt == mem_wait);
            mcnt++;
        end
    end

    // Transaction model: owner 0 = none, 1 = fetch, 2 = data.
    int          m_owner, m_start, m_cyc, m_last;
    bit          m_armed;
    logic        e_mreq, e_rw, e_iack, e_dack, e_err;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;

    assign e_mreq = (m_owner != 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = 0; m_start = 0; m_cyc = 0; m_last = 2; m_armed = 1'b0;
            e_rw = 0; e_iack = 0; e_dack = 0; e_err = 0;
            e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
        end else begin
            bit ie, de, fail;
            int pick, waited;
            ie = bus.i_req && !e_iack;
            de = bus.d_req && !e_dack;
            e_iack = 0; e_dack = 0; e_err = 0;
            if (m_owner != 0) begin
                waited = m_cyc - m_start + 1;
                if (bus.m_ack || waited == TO) begin
                    fail = !bus.m_ack;
                    if (m_owner == 1) begin
                        e_iack   = 1;
                        e_irdata = fail ? 32'h0 : bus.m_rdata;
                    end else begin
                        e_dack = 1;
                        if (fail) e_drdata = 32'h0;
                        else if (!e_rw) e_drdata = bus.m_rdata;
                    end
                    e_err   = fail;
                    m_owner = 0;
                end
            end else if (m_armed && (ie || de)) begin
                if (ie && de) begin
`ifdef ARB_ROUND_ROBIN_EN
                    pick = (m_last == 1) ? 2 : 1;
`else
                    pick = 2;
`endif
                end else begin
                    pick = ie ? 1 : 2;
                end
                m_owner = pick;
                m_start = m_cyc + 1;
                m_last  = pick;
                if (pick == 1) begin
                    e_rw = 0; e_addr = bus.i_addr; e_wdata = 0;
                end else begin
                    e_rw = bus.d_rw; e_addr = bus.d_addr;
                    e_wdata = bus.d_rw ? bus.d_wdata : 32'h0;
                end
            end
            m_armed = 1'b1;
            m_cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            chk("m_req",   {31'b0, bus.m_req}, {31'b0, e_mreq});
            chk("m_rw",    {31'b0, bus.m_rw},  {31'b0, e_rw});
            chk("m_addr",  bus.m_addr,  e_addr);
            chk("m_wdata", bus.m_wdata, e_wdata);
            chk("i_ack",   {31'b0, bus.i_ack}, {31'b0, e_iack});
            chk("d_ack",   {31'b0, bus.d_ack}, {31'b0, e_dack});
            chk("err",     {31'b0, bus.err},   {31'b0, e_err});
            chk("i_rdata", bus.i_rdata, e_irdata);
            chk("d_rdata", bus.d_rdata, e_drdata);
        end
    end

    // Poll for a port's ack after each edge; returns edges taken.
    task automatic wait_ack(input bit is_d, input int limit, output int edges);
        bit got;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            got = is_d ? bus.d_ack : bus.i_ack;
        end
        if (!got) begin
            n_checks++;
            n_err++;
            $display("FAIL ack_wait: no ack after %0d edges, expected one", edges);
        end
    endtask

    task automatic wait_any(output int who);
        int n;
        who = 0;
        n   = 0;
        while (who == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.i_ack) who = 1;
            else if (bus.d_ack) who = 2;
        end
        if (who == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL ack_wait_any: no ack after %0d edges, expected one", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int who;
        int order[4];
        int exp_order[4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 1; exp_order[3] = 2;
`else
        // Data wins contention; its own ack cycle leaves fetch as the sole eligible port.
        exp_order[0] = 2; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 1;
`endif
        reset = 1'b1;
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_rw = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.m_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_m_req",   {31'b0, bus.m_req}, 32'h0);
        chk("rst_m_addr",  bus.m_addr, 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        chk("rst_err",     {31'b0, bus.err}, 32'h0);

        // Fetch with request already up at reset release; memory acks after 2 waits.
        bus.i_addr = 32'h0000_1000; bus.i_req = 1; mem_wait = 2;
        bus.m_rdata = 32'hDEAD_BEEF;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("first_edge_no_grant", {31'b0, bus.m_req}, 32'h0);
        @(posedge clk); #1;
        chk("second_edge_grant", {31'b0, bus.m_req}, 32'h1);
        chk("fetch_rw",   {31'b0, bus.m_rw}, 32'h0);
        chk("fetch_addr", bus.m_addr, 32'h0000_1000);
        wait_ack(0, 20, e);
        chk("fetch_ack_edges", e, 3);
        chk("fetch_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        chk("fetch_err", {31'b0, bus.err}, 32'h0);
        @(negedge clk); bus.i_req = 0;
        @(posedge clk); #1;
        chk("fetch_ack_one_cycle", {31'b0, bus.i_ack}, 32'h0);

        // Data write, zero-wait memory; read data must stay untouched.
        @(negedge clk);
        bus.d_req = 1; bus.d_rw = 1; bus.d_addr = 32'h10; bus.d_wdata = 32'h1234_5678;
        mem_wait = 0; bus.m_rdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        chk("wr_m_req",   {31'b0, bus.m_req}, 32'h1);
        chk("wr_m_rw",    {31'b0, bus.m_rw}, 32'h1);
        chk("wr_m_addr",  bus.m_addr, 32'h10);
        chk("wr_m_wdata", bus.m_wdata, 32'h1234_5678);
        wait_ack(1, 20, e);
        chk("wr_ack_edges", e, 1);
        chk("wr_d_rdata_kept", bus.d_rdata, 32'h0);
        @(negedge clk); bus.d_req = 0;
        @(posedge clk); #1;
        chk("wr_ack_one_cycle", {31'b0, bus.d_ack}, 32'h0);

        // Data read, one wait cycle.
        @(negedge clk);
        bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h20; mem_wait = 1;
        bus.m_rdata = 32'hCAFE_F00D;
        wait_ack(1, 20, e);
        chk("rd_ack_edges", e, 3);
        chk("rd_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
        chk("rd_m_wdata_zero", bus.m_wdata, 32'h0);
        @(negedge clk); bus.d_req = 0;

        // Both ports held for four zero-wait accesses.
        @(negedge clk);
        bus.i_req = 1; bus.i_addr = 32'h100;
        bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h200;
        mem_wait = 0; bus.m_rdata = 32'h5A5A_0001;
        for (int k = 0; k < 4; k++) begin
            wait_any(who);
            order[k] = who;
        end
        @(negedge clk); bus.i_req = 0; bus.d_req = 0;
        for (int k = 0; k < 4; k++) chk($sformatf("contend_order_%0d", k), order[k], exp_order[k]);

        // Timeout: memory never acks.
        @(negedge clk);
        bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h40; mem_wait = 255;
        bus.m_rdata = 32'h7777_7777;
        wait_ack(1, 20, e);
        chk("to_ack_edges", e, 5);
        chk("to_err", {31'b0, bus.err}, 32'h1);
        chk("to_d_rdata", bus.d_rdata, 32'h0);
        @(negedge clk); bus.d_req = 0;
        @(posedge clk); #1;
        chk("to_err_one_cycle", {31'b0, bus.err}, 32'h0);

        // Ack arrives in the timeout cycle: completion wins.
        @(negedge clk);
        bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h44; mem_wait = 3;
        bus.m_rdata = 32'h1357_2468;
        wait_ack(1, 20, e);
        chk("late_ack_edges", e, 5);
        chk("late_ack_err", {31'b0, bus.err}, 32'h0);
        chk("late_ack_rdata", bus.d_rdata, 32'h1357_2468);
        @(negedge clk); bus.d_req = 0;

        // Reset in the middle of a fetch grant.
        @(negedge clk);
        bus.i_req = 1; bus.i_addr = 32'h300; mem_wait = 255;
        @(posedge clk); #1;
        chk("mid_grant_m_req", {31'b0, bus.m_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_m_req", {31'b0, bus.m_req}, 32'h0);
        chk("rst_async_i_ack", {31'b0, bus.i_ack}, 32'h0);
        chk("rst_async_err",   {31'b0, bus.err}, 32'h0);
        chk("rst_async_addr",  bus.m_addr, 32'h0);
        @(negedge clk);
        bus.d_req = 1; bus.d_rw = 0; bus.d_addr = 32'h400; mem_wait = 0;
        bus.m_rdata = 32'h0BAD_F00D;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_no_grant", {31'b0, bus.m_req}, 32'h0);
        @(posedge clk); #1;
        chk("post_rst_grant", {31'b0, bus.m_req}, 32'h1);
`ifdef ARB_ROUND_ROBIN_EN
        chk("post_rst_winner", bus.m_addr, 32'h300);
`else
        chk("post_rst_winner", bus.m_addr, 32'h400);
`endif
        wait_any(who);
        @(negedge clk); bus.i_req = 0; bus.d_req = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
